// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared FIFO parameters and read-controller state type
package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } rd_ctrl_state_e;

endpackage

// File: rtl/fifo_rd_ctrl_sva.sv
// rtl/fifo_rd_ctrl_sva.sv - protocol assertions bound into fifo_rd_ctrl
//
// Purpose: no read while empty, buffer occupancy bound, head stable under back-pressure.
// Ports: observation-only copies of the controller's clock, reset, flags and stream.
module fifo_rd_ctrl_sva
    import shared_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    input logic                  empty,
    input logic                  flush,
    input logic                  rd_en,
    input logic                  m_valid,
    input logic                  m_ready,
    input logic [1:0]            occ,
    input logic [FIFO_WIDTH-1:0] m_data
);

    a_no_rd_when_empty: assert property (@(posedge clk) disable iff (rst)
        empty |-> !rd_en);

    a_occ_max: assert property (@(posedge clk) disable iff (rst)
        occ <= 2'd2);

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));

endmodule

bind fifo_rd_ctrl fifo_rd_ctrl_sva u_sva (
    .clk    (clk),
    .rst    (rst),
    .empty  (empty),
    .flush  (flush),
    .rd_en  (rd_en),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .occ    (occ),
    .m_data (m_data)
);

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry in-order output buffer for the FIFO read side
//
// Purpose: holds up to two words captured from the FIFO and presents the
// oldest one as a registered head word with a registered valid.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push, din  write din at the tail
//   pop        remove the head word
//   clear      discard all entries (wins over push/pop)
//   occ        current occupancy, 0..2
//   valid      registered head-valid
//   head       registered head word
module fifo_rd_skid
    import shared_pkg::*;
#(
    parameter int W = FIFO_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [1:0]   occ,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   occ_q, occ_d;
    logic         valid_q, valid_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        if (clear) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        slot0_d = din;
                    end else begin
                        slot1_d = din;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    // slot1 shifts forward; stale if occ was 1, but valid drops then
                    slot0_d = slot1_q;
                    occ_d   = occ_q - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; the new word lands behind whatever remains
                    if (occ_q == 2'd1) begin
                        slot0_d = din;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = din;
                    end
                end
                default: begin
                end
            endcase
        end
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign occ   = occ_q;
    assign valid = valid_q;
    assign head  = slot0_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read-side drain controller with valid/ready output
//
// Purpose: issues FIFO reads against a 2-word credit, captures the read data
// one cycle later into fifo_rd_skid and streams it downstream at full rate.
// Also provides flush, a delivered-word counter and a sticky underflow flag.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   empty           FIFO empty flag
//   underflow       FIFO underflow indication
//   data_out        FIFO read data, valid the cycle after rd_en
//   rd_en           FIFO read request (combinational)
//   m_valid/m_data  downstream word (registered)
//   m_ready         downstream accept
//   flush           discard buffered and in-flight words
//   rd_count        words delivered, wraps
//   err_underflow   sticky underflow flag
module fifo_rd_ctrl
    import shared_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_W-1:0]      rd_count,
    output logic                  err_underflow
);

    rd_ctrl_state_e   state_q, state_d;
    logic             infl_q, infl_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic             err_underflow_q, err_underflow_d;

    logic [1:0] occ;
    logic       pop;
    logic       push;
    logic [2:0] credit;

    assign pop = m_valid && m_ready;

    // Slots committed after this edge: buffered words plus the arriving one,
    // minus the word leaving now. A read is only issued if a slot remains for it.
    assign credit = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};

    assign rd_en = !rst && !empty && (state_q != FLUSH) && !flush && (credit < 3'd2);

    // Data arriving during a flush (or right after one) belongs to the discarded stream.
    assign push = infl_q && (state_q != FLUSH) && !flush;

    fifo_rd_skid #(
        .W(FIFO_WIDTH)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .clear(flush),
        .din  (data_out),
        .occ  (occ),
        .valid(m_valid),
        .head (m_data)
    );

    always_comb begin
        state_d         = state_q;
        infl_d          = rd_en;
        rd_count_d      = rd_count_q + {{(CNT_W-1){1'b0}}, pop};
        err_underflow_d = err_underflow_q | underflow;
        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_en) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if ((occ == 2'd0) && !infl_q && !rd_en) begin
                        state_d = IDLE;
                    end
                end
                FLUSH: begin
                    // rd_en is held off while flushing, so nothing is in flight past one cycle
                    if (!infl_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            infl_q          <= 1'b0;
            rd_count_q      <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            infl_q          <= infl_d;
            rd_count_q      <= rd_count_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign rd_count      = rd_count_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;
    import shared_pkg::*;

    localparam int W = FIFO_WIDTH;

    logic         clk = 1'b0;
    logic         rst, empty, underflow, m_ready, flush;
    logic [W-1:0] data_out;
    logic         rd_en, m_valid, err_underflow;
    logic [W-1:0] m_data;
    logic [31:0]  rd_count;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .empty        (empty),
        .underflow    (underflow),
        .data_out     (data_out),
        .rd_en        (rd_en),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .flush        (flush),
        .rd_count     (rd_count),
        .err_underflow(err_underflow)
    );

    int total = 0;
    int bad   = 0;

    // Environment FIFO: words waiting, and the word read last cycle.
    logic [W-1:0] fifo_q[$];
    logic         pend;
    logic [W-1:0] pend_word;

    // Reference: words held for downstream, in order, plus counters.
    logic [W-1:0] ref_buf[$];
    logic         ref_flush_prev;
    logic [31:0]  ref_count;
    logic         ref_err;

    // Values sampled in the most recent cycle.
    logic         last_rd_en, last_valid, last_err;
    logic [W-1:0] last_data;
    logic [31:0]  last_count;

    typedef struct {
        logic        v_rst;
        logic        v_ready;
        logic        e_rd_en;
        logic        e_valid;
        logic        chk_data;
        logic [15:0] e_data;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at the negative edge.
    task automatic cycle(input logic i_rst, input logic i_ready, input logic i_flush, input logic i_uf);
        logic exp_rd_en;
        logic exp_pop;
        int   committed;
        rst       = i_rst;
        m_ready   = i_ready;
        flush     = i_flush;
        underflow = i_uf;
        empty     = (fifo_q.size() == 0);
        data_out  = pend ? pend_word : W'($urandom);
        #1;
        exp_pop   = (ref_buf.size() > 0) && i_ready;
        committed = ref_buf.size() + (pend ? 1 : 0) - (exp_pop ? 1 : 0);
        exp_rd_en = !i_rst && !empty && !i_flush && !ref_flush_prev && (committed < 2);
        check("rd_en", {31'b0, rd_en}, {31'b0, exp_rd_en});
        check("m_valid", {31'b0, m_valid}, {31'b0, ref_buf.size() > 0});
        if (ref_buf.size() > 0) begin
            check("m_data", {16'b0, m_data}, {16'b0, ref_buf[0]});
        end
        check("rd_count", rd_count, ref_count);
        check("err_underflow", {31'b0, err_underflow}, {31'b0, ref_err});
        last_rd_en = rd_en;
        last_valid = m_valid;
        last_data  = m_data;
        last_count = rd_count;
        last_err   = err_underflow;
        if (i_rst) begin
            ref_buf.delete();
            ref_count      = '0;
            ref_err        = 1'b0;
            ref_flush_prev = 1'b0;
        end else begin
            if (exp_pop) begin
                void'(ref_buf.pop_front());
                ref_count = ref_count + 32'd1;
            end
            if (i_flush) begin
                ref_buf.delete();
            end else if (pend && !ref_flush_prev) begin
                ref_buf.push_back(pend_word);
            end
            ref_flush_prev = i_flush;
            ref_err        = ref_err | i_uf;
        end
        if (rd_en && fifo_q.size() > 0) begin
            pend      = 1'b1;
            pend_word = fifo_q.pop_front();
        end else begin
            pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic rd, input logic v,
                                input logic cd, input logic [15:0] d, input logic [31:0] c);
        vec_t t;
        t.v_rst = r; t.v_ready = 1'b1; t.e_rd_en = rd; t.e_valid = v;
        t.chk_data = cd; t.e_data = d; t.e_count = c;
        return t;
    endfunction

    initial begin
        logic [W-1:0] got[$];
        int           reads;
        int           guard;

        pend = 1'b0; pend_word = '0;
        ref_flush_prev = 1'b0; ref_count = '0; ref_err = 1'b0;
        rst = 1'b1; empty = 1'b0; underflow = 1'b0; m_ready = 1'b1; flush = 1'b0; data_out = '0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
        @(posedge clk);
        @(negedge clk);

        // Reset then streaming of 0x0001..0x0008 with m_ready high.
        vecs[0]  = mk(1, 0, 0, 1, 16'h0000, 0);
        vecs[1]  = mk(1, 0, 0, 1, 16'h0000, 0);
        vecs[2]  = mk(0, 1, 0, 0, 16'h0000, 0);
        vecs[3]  = mk(0, 1, 0, 0, 16'h0000, 0);
        vecs[4]  = mk(0, 1, 1, 1, 16'h0001, 0);
        vecs[5]  = mk(0, 1, 1, 1, 16'h0002, 1);
        vecs[6]  = mk(0, 1, 1, 1, 16'h0003, 2);
        vecs[7]  = mk(0, 1, 1, 1, 16'h0004, 3);
        vecs[8]  = mk(0, 1, 1, 1, 16'h0005, 4);
        vecs[9]  = mk(0, 1, 1, 1, 16'h0006, 5);
        vecs[10] = mk(0, 0, 1, 1, 16'h0007, 6);
        vecs[11] = mk(0, 0, 1, 1, 16'h0008, 7);
        vecs[12] = mk(0, 0, 0, 0, 16'h0000, 8);
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].v_rst, vecs[i].v_ready, 1'b0, 1'b0);
            check($sformatf("vec%0d_rd_en", i), {31'b0, last_rd_en}, {31'b0, vecs[i].e_rd_en});
            check($sformatf("vec%0d_valid", i), {31'b0, last_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), {16'b0, last_data}, {16'b0, vecs[i].e_data});
            check($sformatf("vec%0d_count", i), last_count, vecs[i].e_count);
            check($sformatf("vec%0d_err", i), {31'b0, last_err}, 32'd0);
        end

        // Back-pressure: 10 stalled cycles allow exactly two reads.
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0);
            reads += int'(last_rd_en);
        end
        check("bp_reads", reads, 2);
        check("bp_hold_valid", {31'b0, last_valid}, 32'd1);
        check("bp_hold_data", {16'b0, last_data}, 32'h0001);
        got.delete();
        guard = 0;
        while (got.size() < 8 && guard < 60) begin
            cycle(0, 1, 0, 0);
            if (last_valid) got.push_back(last_data);
            guard++;
        end
        check("bp_delivered", got.size(), 8);
        for (int i = 0; i < got.size(); i++) check($sformatf("bp_word%0d", i), {16'b0, got[i]}, i + 1);
        cycle(0, 1, 0, 0);
        check("bp_count", last_count, 8);

        // Flush while the third word is in flight: next delivered is the fourth.
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) fifo_q.push_back(W'(16'h0010 + i));
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("fl_pop_reads", {31'b0, last_rd_en}, 32'd1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check("fl_valid_dropped", {31'b0, last_valid}, 32'd0);
        check("fl_count_kept", last_count, 1);
        guard = 0;
        while (!last_valid && guard < 10) begin
            cycle(0, 1, 0, 0);
            guard++;
        end
        check("fl_next_valid", {31'b0, last_valid}, 32'd1);
        check("fl_next_word", {16'b0, last_data}, 32'h0014);

        // Sticky underflow flag.
        cycle(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        check("uf_sticky", {31'b0, last_err}, 32'd1);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("uf_cleared", {31'b0, last_err}, 32'd0);

        // Counter wrap from all-ones.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        force dut.rd_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_count_q;
        ref_count = 32'hFFFF_FFFF;
        cycle(0, 1, 0, 0);
        check("wrap_preset", last_count, 32'hFFFF_FFFF);
        fifo_q.push_back(16'hBEEF);
        guard = 0;
        last_valid = 1'b0;
        while (!last_valid && guard < 10) begin
            cycle(0, 1, 0, 0);
            guard++;
        end
        check("wrap_word", {16'b0, last_data}, 32'hBEEF);
        cycle(0, 1, 0, 0);
        check("wrap_zero", last_count, 0);

        // Randomized traffic against the reference model.
        cycle(1, 0, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            if (fifo_q.size() < FIFO_DEPTH && ($urandom % 3) != 0) fifo_q.push_back(W'($urandom));
            cycle(($urandom % 211) == 0,
                  ($urandom % 4) != 0,
                  ($urandom % 25) == 0,
                  ($urandom % 97) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
